// File: rtl/uart_top_if.sv
// Loopback UART client bus: byte/request in, status and received byte out.
//   data_in   : byte to transmit, latched at frame start
//   transmit  : level-sensitive transmit request
//   TX_active : transmitter busy, start bit through stop bit
//   valid     : one-cycle strobe, good byte on data_out
//   error     : one-cycle strobe, stop bit sampled low
//   data_out  : last good received byte
interface uart_top_if;
    logic [7:0] data_in;
    logic       transmit;
    logic       TX_active;
    logic       valid;
    logic       error;
    logic [7:0] data_out;

    modport master (
        output data_in, transmit,
        input  TX_active, valid, error, data_out
    );

    modport slave (
        input  data_in, transmit,
        output TX_active, valid, error, data_out
    );
endinterface

// File: rtl/uart_top.sv
// UART 8N1 transmitter looped back into a UART receiver.
//   clk   : rising-edge clock for all logic
//   reset : synchronous, active-high
//   bus   : uart_top_if slave (data_in/transmit in; TX_active/valid/error/data_out out)
module uart_top #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    uart_top_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_CLEANUP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    tx_state_t        tx_state;
    logic [CNT_W-1:0] tx_cnt;
    logic [2:0]       tx_idx;
    logic [7:0]       tx_shift;
    logic             tx_serial;
    logic             tx_active;

    rx_state_t        rx_state;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       rx_idx;
    logic [7:0]       rx_byte;
    logic [7:0]       data_out_q;
    logic             valid_q;
    logic             error_q;

    // Internal loopback line
    logic             rx_serial;
    assign rx_serial = tx_serial;

    // Transmitter: line and TX_active are registered alongside the state
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state  <= TX_IDLE;
            tx_cnt    <= '0;
            tx_idx    <= '0;
            tx_shift  <= '0;
            tx_serial <= 1'b1;
            tx_active <= 1'b0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    tx_serial <= 1'b1;
                    tx_active <= 1'b0;
                    tx_cnt    <= '0;
                    tx_idx    <= '0;
                    if (bus.transmit) begin
                        tx_shift  <= bus.data_in;
                        tx_serial <= 1'b0;
                        tx_active <= 1'b1;
                        tx_state  <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt    <= '0;
                        tx_serial <= tx_shift[0];
                        tx_state  <= TX_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + CNT_W'(1);
                    end
                end
                TX_DATA: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_idx == 3'd7) begin
                            tx_serial <= 1'b1;
                            tx_state  <= TX_STOP;
                        end else begin
                            tx_idx    <= tx_idx + 3'd1;
                            tx_serial <= tx_shift[tx_idx + 3'd1];
                        end
                    end else begin
                        tx_cnt <= tx_cnt + CNT_W'(1);
                    end
                end
                TX_STOP: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt    <= '0;
                        tx_active <= 1'b0;
                        tx_state  <= TX_CLEANUP;
                    end else begin
                        tx_cnt <= tx_cnt + CNT_W'(1);
                    end
                end
                TX_CLEANUP: begin
                    tx_serial <= 1'b1;
                    tx_state  <= TX_IDLE;
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    // Receiver: half-bit start qualification, then mid-bit sampling
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rx_idx     <= '0;
            rx_byte    <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            error_q <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt <= '0;
                    rx_idx <= '0;
                    if (!rx_serial) rx_state <= RX_START;
                end
                RX_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        // A line back high at mid start bit is a glitch, not a frame
                        rx_state <= rx_serial ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt          <= '0;
                        rx_byte[rx_idx] <= rx_serial;
                        if (rx_idx == 3'd7) rx_state <= RX_STOP;
                        else                rx_idx   <= rx_idx + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_IDLE;
                        if (rx_serial) begin
                            data_out_q <= rx_byte;
                            valid_q    <= 1'b1;
                        end else begin
                            error_q    <= 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + CNT_W'(1);
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    assign bus.TX_active = tx_active;
    assign bus.valid     = valid_q;
    assign bus.error     = error_q;
    assign bus.data_out  = data_out_q;
endmodule

// File: tb/tb_uart_top.sv
// Directed bench for the loopback UART: table of bytes plus multi-cycle corner sequences.
module tb_uart_top;
    localparam int CPB = 16;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_bad;

    uart_top_if bus ();

    uart_top #(.CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic [7:0] exp_data;
        int         exp_active;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Wait (bounded) for TX_active to be seen high at a falling edge
    task automatic wait_rise(input string tag);
        int t;
        t = 0;
        @(negedge clk);
        while (bus.TX_active !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check({tag, " tx_start"}, 32'(bus.TX_active), 32'd1);
    endtask

    // One isolated frame; checks timing, line waveform and received byte
    task automatic run_frame(input logic [7:0] din, input logic [7:0] exp_byte,
                             input int exp_active, input string tag);
        int alen, vcnt, vpos, ecnt;
        logic va;
        logic [9:0] line;
        bus.data_in  = din;
        bus.transmit = 1'b1;
        wait_rise(tag);
        bus.transmit = 1'b0;
        alen = 0; vcnt = 0; vpos = -1; ecnt = 0; va = 1'b0; line = '0;
        for (int c = 1; c <= 175; c++) begin
            if (c > 1) @(negedge clk);
            if (bus.TX_active === 1'b1) alen++;
            if (bus.valid === 1'b1) begin
                vcnt++;
                vpos = c - 1;
                va   = bus.TX_active;
            end
            if (bus.error === 1'b1) ecnt++;
            if ((c % CPB) == CPB / 2 && c <= 10 * CPB) line[c / CPB] = dut.tx_serial;
        end
        check({tag, " active_len"}, 32'(alen), 32'(exp_active));
        check({tag, " valid_count"}, 32'(vcnt), 32'd1);
        check({tag, " valid_window"}, 32'(vpos >= 152 && vpos <= 155), 32'd1);
        check({tag, " active_at_valid"}, 32'(va), 32'd1);
        check({tag, " error_count"}, 32'(ecnt), 32'd0);
        check({tag, " data_out"}, 32'(bus.data_out), 32'(exp_byte));
        check({tag, " line_bits"}, 32'(line), 32'({1'b1, exp_byte, 1'b0}));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int vcnt, gap, rises, ecnt, t;
        logic prev_act, fell;
        logic [7:0] vals [2];

        n_vec = 0;
        n_bad = 0;
        vecs[0] = '{8'hAC, 8'hAC, 160};
        vecs[1] = '{8'h00, 8'h00, 160};
        vecs[2] = '{8'hFF, 8'hFF, 160};
        vecs[3] = '{8'h01, 8'h01, 160};
        vecs[4] = '{8'h5A, 8'h5A, 160};
        vecs[5] = '{8'h80, 8'h80, 160};

        // Reset held 3 cycles with transmit requested: nothing may start
        reset        = 1'b1;
        bus.transmit = 1'b1;
        bus.data_in  = 8'hAC;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst TX_active", 32'(bus.TX_active), 32'd0);
            check("rst valid", 32'(bus.valid), 32'd0);
            check("rst error", 32'(bus.error), 32'd0);
            check("rst data_out", 32'(bus.data_out), 32'h00);
            check("rst line", 32'(dut.tx_serial), 32'd1);
        end
        reset = 1'b0;

        foreach (vecs[i])
            run_frame(vecs[i].data, vecs[i].exp_data, vecs[i].exp_active, $sformatf("vec%0d", i));

        // Back-to-back frames with data_in changed mid-frame
        bus.data_in  = 8'hAC;
        bus.transmit = 1'b1;
        wait_rise("b2b");
        vcnt = 0; gap = 0; rises = 0; fell = 1'b0; prev_act = 1'b1;
        vals[0] = '0; vals[1] = '0;
        for (int c = 2; c <= 400; c++) begin
            @(negedge clk);
            if (c == 50) bus.data_in = 8'h35;
            if (bus.valid === 1'b1) begin
                if (vcnt < 2) vals[vcnt] = bus.data_out;
                vcnt++;
            end
            if (prev_act && !bus.TX_active && rises == 0) fell = 1'b1;
            if (fell && rises == 0 && !bus.TX_active) gap++;
            if (!prev_act && bus.TX_active && fell) begin
                rises++;
                bus.transmit = 1'b0;
            end
            prev_act = bus.TX_active;
        end
        check("b2b valid_count", 32'(vcnt), 32'd2);
        check("b2b first", 32'(vals[0]), 32'hAC);
        check("b2b second", 32'(vals[1]), 32'h35);
        check("b2b gap", 32'(gap), 32'd2);
        check("b2b restarts", 32'(rises), 32'd1);

        // Reset during the frame following a valid pulse
        bus.data_in  = 8'h96;
        bus.transmit = 1'b1;
        wait_rise("rmid");
        t = 0;
        while (bus.valid !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("rmid valid_seen", 32'(bus.valid), 32'd1);
        check("rmid data_out", 32'(bus.data_out), 32'h96);
        repeat (10) @(negedge clk);
        check("rmid next_frame", 32'(bus.TX_active), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rmid TX_active", 32'(bus.TX_active), 32'd0);
        check("rmid valid", 32'(bus.valid), 32'd0);
        check("rmid error", 32'(bus.error), 32'd0);
        check("rmid data_out_clr", 32'(bus.data_out), 32'h00);
        @(negedge clk);
        reset        = 1'b0;
        bus.transmit = 1'b0;
        vcnt = 0; ecnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.valid === 1'b1) vcnt++;
            if (bus.error === 1'b1) ecnt++;
        end
        check("rmid quiet_valid", 32'(vcnt), 32'd0);
        check("rmid quiet_error", 32'(ecnt), 32'd0);
        run_frame(8'hC3, 8'hC3, 160, "rmid_after");

        // Framing error: hold the receiver line low across the stop-bit sample
        bus.data_in  = 8'h5A;
        bus.transmit = 1'b1;
        wait_rise("ferr");
        bus.transmit = 1'b0;
        vcnt = 0; ecnt = 0;
        for (int c = 2; c <= 220; c++) begin
            @(negedge clk);
            if (c == 146) force dut.rx_serial = 1'b0;
            if (c == 158) release dut.rx_serial;
            if (bus.valid === 1'b1) vcnt++;
            if (bus.error === 1'b1) ecnt++;
        end
        check("ferr error_cycles", 32'(ecnt), 32'd1);
        check("ferr valid_count", 32'(vcnt), 32'd0);
        check("ferr data_out_hold", 32'(bus.data_out), 32'hC3);
        run_frame(8'hA5, 8'hA5, 160, "ferr_after");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_top.md
# uart_top

UART loopback top level. It pairs an 8-bit UART transmitter with an 8-bit UART receiver, and the transmitter's serial output drives the receiver's serial input internally. A byte presented on `data_in` is serialised as an 8N1 frame, received back, and presented on `data_out` with a one-cycle `valid` strobe. Framing errors are flagged on `error`. The block serves as a self-checking UART core and as the integration point for the standalone TX and RX engines.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit. Legal values are ≥ 4.
- `clk` input, 1 bit: single clock for all logic, rising edge.
- `reset` input, 1 bit: synchronous, active-high reset.
- `data_in` input, 8 bits: byte to transmit. It is latched when a frame starts.
- `transmit` input, 1 bit: level-sensitive transmit request.
- `TX_active` output, 1 bit: high while the transmitter is sending a frame, from the start bit through the stop bit.
- `valid` output, 1 bit: one-cycle pulse when a byte with a good stop bit has been received.
- `error` output, 1 bit: one-cycle pulse when the stop bit is sampled low (framing error).
- `data_out` output, 8 bits: last received byte. It holds its value until the next reception.

## Operation
- Frame format: 1 start bit (0), 8 data bits sent LSB first, 1 stop bit (1). There is no parity. The idle line level is 1.
- Each bit occupies exactly `CLKS_PER_BIT` cycles.
- TX state machine: IDLE → START → DATA → STOP → CLEANUP → IDLE.
  - IDLE: line is 1 and `TX_active` is 0. If `transmit`=1, latch `data_in` into the shift register and go to START.
  - START: line is 0 for `CLKS_PER_BIT` cycles.
  - DATA: 8 bits, LSB first, each for `CLKS_PER_BIT` cycles. A 3-bit index counts from 0 to 7.
  - STOP: line is 1 for `CLKS_PER_BIT` cycles.
  - CLEANUP: 1 cycle with line 1 and `TX_active` 0, then go to IDLE.
  - If `transmit` stays high, frames repeat back-to-back, separated by the CLEANUP and IDLE cycles.
  - Changes to `data_in` during a frame have no effect on that frame.
- RX state machine: IDLE → START → DATA → STOP → IDLE.
  - IDLE: wait for the line to go 0.
  - START: count `CLKS_PER_BIT/2` cycles and re-check the line.
    - If the line is still 0, go to DATA.
    - If it is 1, treat it as a glitch and return to IDLE with no `error`.
  - DATA: sample every `CLKS_PER_BIT` cycles (mid-bit). Shift each sample into bit position `index`, 8 samples total.
  - STOP: sample mid-bit.
    - If the sample is 1: load `data_out` with the received byte and pulse `valid` for 1 cycle.
    - If the sample is 0: pulse `error` for 1 cycle and leave `data_out` unchanged.
    - Either way, return to IDLE.
- `valid` and `error` are never high in the same cycle.
- In loopback with correct RTL, `error` never asserts.

## Timing
- Reset, applied on a rising edge with `reset`=1:
  - both state machines go to IDLE and all counters clear;
  - the TX line is 1;
  - `TX_active`=0, `valid`=0, `error`=0, `data_out`=8'h00.
- Reset takes priority over everything else. Reset mid-frame aborts both TX and RX with no `valid` or `error` pulse.
- After reset deasserts, if `transmit` is high, a new frame starts from the next IDLE cycle.
- All outputs are registered.
- `TX_active` rises on the first edge after `transmit` is sampled high in IDLE. It is high for exactly 10×`CLKS_PER_BIT` cycles.
- `valid` pulses between 9.5×`CLKS_PER_BIT` and 9.5×`CLKS_PER_BIT`+3 cycles after `TX_active` rises. `TX_active` is still high at that point.
- Counter widths must hold `CLKS_PER_BIT`−1 without overflow.

## Test plan
- Single byte: reset, then `data_in`=8'hAC with `transmit`=1 → `TX_active` high for 160 cycles; `valid` pulses once within the window; `data_out`=8'hAC; `error`=0.
- Reset values: assert `reset` for 3 cycles with `transmit`=1 → all outputs are 0, `data_out`=8'h00, and no frame starts while `reset` is high.
- Back-to-back: hold `transmit`=1 and change `data_in` from 8'hAC to 8'h35 mid-frame → first `valid` gives 8'hAC, second `valid` gives 8'h35; `TX_active` is low for exactly 2 cycles between frames.
- Reset mid-operation: assert `reset` 10 cycles after a `valid` pulse, during the next frame → `TX_active` and `valid` are 0 and `data_out`=8'h00 immediately; after release, the next frame completes correctly.
- Boundary data: send 8'h00, 8'hFF and 8'h01 → each is received exactly; bit order is checked via the 8'h01 line waveform (low for 1 bit time, then high for 1 bit time).
- Framing error: force the internal RX line low during the stop bit → `error` pulses for 1 cycle, there is no `valid` pulse, and `data_out` keeps its previous value.
